alsu_arbiter: RTL
=================

ALSU_ARBITER -- requirements
Module: alsu_arbiter

Interface
REQ-001 Parameter LAT, default 2: ALSU input-to-output latency in cycles; legal range 1..4.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 r0_valid, r1_valid  in  1 each  requester command valid.
REQ-005 r0_ready, r1_ready  out  1 each  command accepted this cycle; accept = valid & ready.
REQ-006 r0_cmd, r1_cmd  in  16 each  packed {opcode[15:13], A[12:10], B[9:7], cin[6], serial_in[5], red_op_A[4], red_op_B[3], bypass_A[2], bypass_B[1], direction[0]}.
REQ-007 r0_lock, r1_lock  in  1 each  keep grant for the next command.
REQ-008 alsu_opcode  out  3  opcode to shared ALSU.
REQ-009 alsu_A, alsu_B  out  3 each  signed operands to ALSU.
REQ-010 alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction  out  1 each  ALSU controls.
REQ-011 alsu_out  in  6  ALSU result.
REQ-012 r0_resp_valid, r1_resp_valid  out  1 each  one-cycle result pulse; no backpressure.
REQ-013 resp_data  out  6  result; shared by both requesters.
REQ-014 resp_err  out  1  command was invalid; qualified by either resp_valid.
REQ-015 err_cnt  out  8  saturating count of invalid commands.

Function
REQ-016 Arbiter SHALL accept at most one command per cycle; ready is asserted to at most one requester per cycle.
REQ-017 Without lock, grant SHALL be round-robin: when both valid, the requester not granted last wins; r0 wins the first tie after reset.
REQ-018 If the requester accepted in cycle k had lock=1 at acceptance, the arbiter SHALL enter LOCKED and grant only that requester until it is accepted with lock=0; the other requester's ready stays 0 meanwhile.
REQ-019 In LOCKED, if the owner drops valid, the arbiter SHALL hold LOCKED and drive idle command; there is no timeout.
REQ-020 On acceptance at edge k, the alsu_* outputs SHALL be registered from the accepted cmd at edge k.
REQ-021 In cycles with no acceptance, the alsu_* outputs SHALL be driven to idle: opcode 0, A=B=0, all control bits 0.
REQ-022 Shift/rotate (opcode 4/5) operate on the ALSU's current out; the arbiter SHALL NOT save or restore it per requester.
REQ-023 A tag pipeline of LAT+1 stages SHALL carry {valid, requester id, invalid flag}; a command accepted at edge k yields resp_valid high in the cycle after edge k+LAT+1, with resp_data = alsu_out sampled at that edge.
REQ-024 Back-to-back acceptance SHALL be supported every cycle; responses return in acceptance order, one per cycle.
REQ-025 Invalid flag = (bypass_A|bypass_B)=0 AND (opcode in {6,7} OR ((red_op_A|red_op_B)=1 AND opcode not in {0,1})).
REQ-026 For an invalid command, resp_err SHALL be 1 and resp_data SHALL be 0 regardless of alsu_out.
REQ-027 err_cnt SHALL increment by 1 on each accepted invalid command and saturate at 255.
REQ-028 resp_data/resp_err SHALL hold their last value when no resp_valid is asserted.

Reset
REQ-029 While rst=1: ready, resp_valid, resp_err low; resp_data=0; err_cnt=0; alsu_* at idle; tag pipeline cleared; LOCKED exited; round-robin pointer set to r0.
REQ-030 Commands in flight when rst asserts SHALL be dropped without a response; commands presented during rst are not accepted.

Verification
REQ-031 r0 only: cmd opcode 2, A=3, B=1, cin=1 accepted at edge k -> r0_resp_valid pulse after edge k+3 (LAT=2), resp_data=5, resp_err=0.
REQ-032 Both valid every cycle, no lock -> acceptances alternate r0,r1,r0,...; responses alternate with 1-per-cycle throughput.
REQ-033 r1 accepted with lock=1 then two more r1 commands while r0 valid -> r0_ready stays 0 until r1 accepted with lock=0, then r0 granted next.
REQ-034 r0 cmd opcode 6, no bypass -> resp_err=1, resp_data=0, err_cnt increments; same opcode with bypass_A=1, A=-2 -> resp_data=6'b111110, resp_err=0.
REQ-035 256 invalid commands -> err_cnt=255 and holds; rst mid-stream with 2 in flight -> no resp_valid afterwards, all outputs at reset values.

Source files
------------

// File: rtl/alsu_arbiter.sv
// Two-requester arbiter in front of a shared, pipelined ALSU.
//
// An accepted command is registered onto the alsu_* outputs. A tag travels down a
// LAT+1 stage pipeline next to it and steers the ALSU result back to the requester
// that issued the command. Grant is round-robin. A requester can hold the grant
// across several commands with its lock bit.
//
// Parameters:
//   LAT            ALSU input-to-output latency in cycles (legal 1..4)
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   rN_valid/ready command handshake per requester (accept = valid & ready)
//   rN_cmd         {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
//                   bypass_A, bypass_B, direction}
//   rN_lock        keep the grant for the next command
//   alsu_*         registered command fields to the ALSU; idle (all 0) when nothing accepted
//   alsu_out       ALSU result
//   rN_resp_valid  one-cycle response pulse
//   resp_data/err  shared response payload; held between responses
//   err_cnt        saturating count of accepted invalid commands
module alsu_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r1_valid,
  output logic              r0_ready,
  output logic              r1_ready,
  input  logic [15:0]       r0_cmd,
  input  logic [15:0]       r1_cmd,
  input  logic              r0_lock,
  input  logic              r1_lock,
  output logic [2:0]        alsu_opcode,
  output logic signed [2:0] alsu_A,
  output logic signed [2:0] alsu_B,
  output logic              alsu_cin,
  output logic              alsu_serial_in,
  output logic              alsu_red_op_A,
  output logic              alsu_red_op_B,
  output logic              alsu_bypass_A,
  output logic              alsu_bypass_B,
  output logic              alsu_direction,
  input  logic [5:0]        alsu_out,
  output logic              r0_resp_valid,
  output logic              r1_resp_valid,
  output logic [5:0]        resp_data,
  output logic              resp_err,
  output logic [7:0]        err_cnt
);

  typedef enum logic {StRr, StLocked} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        prio_q;  // requester that wins the next tie

  logic        acc;
  logic        acc_id;
  logic        acc_lock;
  logic        acc_inv;
  logic [15:0] acc_cmd;

  logic [LAT:0] tag_v_q, tag_id_q, tag_inv_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRr: begin
          if (r0_valid && (!r1_valid || !prio_q)) r0_ready = 1'b1;
          else if (r1_valid)                      r1_ready = 1'b1;
        end
        StLocked: begin
          // Only the owner is served; an idle owner leaves the ALSU idle.
          if (owner_q) r1_ready = r1_valid;
          else         r0_ready = r0_valid;
        end
      endcase
    end
    acc      = (r0_valid & r0_ready) | (r1_valid & r1_ready);
    acc_id   = r1_ready;
    acc_cmd  = acc_id ? r1_cmd : r0_cmd;
    acc_lock = acc_id ? r1_lock : r0_lock;
    if (acc) begin
      state_d = acc_lock ? StLocked : StRr;
      owner_d = acc_id;
    end
  end

  // Bypass makes any command legal; otherwise opcodes 6/7 are reserved, and reduction
  // is defined only for AND/XOR (opcodes 0/1).
  assign acc_inv = ~(acc_cmd[2] | acc_cmd[1]) &
                   ((acc_cmd[15:14] == 2'b11) |
                    ((acc_cmd[4] | acc_cmd[3]) & (acc_cmd[15:14] != 2'b00)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRr;
      owner_q       <= 1'b0;
      prio_q        <= 1'b0;
      {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B,
       alsu_bypass_A, alsu_bypass_B, alsu_direction} <= '0;
      tag_v_q       <= '0;
      tag_id_q      <= '0;
      tag_inv_q     <= '0;
      r0_resp_valid <= 1'b0;
      r1_resp_valid <= 1'b0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      err_cnt       <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (acc) prio_q <= ~acc_id;

      {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B,
       alsu_bypass_A, alsu_bypass_B, alsu_direction} <= acc ? acc_cmd : 16'h0000;

      tag_v_q   <= {tag_v_q[LAT-1:0], acc};
      tag_id_q  <= {tag_id_q[LAT-1:0], acc_id};
      tag_inv_q <= {tag_inv_q[LAT-1:0], acc_inv};

      r0_resp_valid <= tag_v_q[LAT] & ~tag_id_q[LAT];
      r1_resp_valid <= tag_v_q[LAT] & tag_id_q[LAT];
      if (tag_v_q[LAT]) begin
        resp_err  <= tag_inv_q[LAT];
        resp_data <= tag_inv_q[LAT] ? 6'd0 : alsu_out;
      end

      if (acc && acc_inv && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
